qpsk_demod: RTL and testbench

Non-coherent hard-decision QPSK demodulator for the 1-bit modulated waveform produced by the team's QPSK modulator. It sits directly downstream of that modulator. Each 8-clock symbol window is correlated against the four 4-chip carrier templates, and the block outputs the recovered 2-bit symbol, a re-serialised bit stream at the modulator's input rate, and a decision-quality flag with a saturating error counter.

---
 rtl/qpsk_pkg.sv | 27 ++
 rtl/qpsk_corr.sv | 36 +++
 rtl/qpsk_demod.sv | 116 +++++++++++
 tb/tb_qpsk_demod.sv | 138 +++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared QPSK constants: symbol/chip geometry and the four carrier templates.
// Template bit i is chip i, so T00 = chips 1,1,0,0 is 4'b0011.
package qpsk_pkg;

    localparam int SYM_W            = 2;
    localparam int SAMPLES_PER_CHIP = 2;
    localparam int CHIPS_PER_SYM    = 4;
    localparam int SAMPLES_PER_SYM  = SAMPLES_PER_CHIP * CHIPS_PER_SYM;
    localparam int METRIC_W         = 4;

    typedef logic [SYM_W-1:0] sym_t;

    localparam logic [CHIPS_PER_SYM-1:0] T00 = 4'b0011;
    localparam logic [CHIPS_PER_SYM-1:0] T01 = 4'b1001;
    localparam logic [CHIPS_PER_SYM-1:0] T10 = 4'b1100;
    localparam logic [CHIPS_PER_SYM-1:0] T11 = 4'b0110;

    function automatic logic [CHIPS_PER_SYM-1:0] template_of(input sym_t s);
        case (s)
            2'b00:   return T00;
            2'b01:   return T01;
            2'b10:   return T10;
            default: return T11;
        endcase
    endfunction

endpackage

// File: rtl/qpsk_corr.sv
// Four parallel template correlators; each metric counts samples matching its
// template chip, and o_metric already includes the sample presented this cycle.
module qpsk_corr
    import qpsk_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   i_sample,
    input  logic [1:0]                             i_chip,
    input  logic                                   i_load,
    output logic [CHIPS_PER_SYM-1:0][METRIC_W-1:0] o_metric
);

    genvar gi;
    generate
        for (gi = 0; gi < CHIPS_PER_SYM; gi++) begin : g_corr
            localparam logic [CHIPS_PER_SYM-1:0] TPL = template_of(sym_t'(gi));

            logic                w_match;
            logic [METRIC_W-1:0] r_acc;

            assign w_match      = (i_sample == TPL[i_chip]);
            assign o_metric[gi] = i_load ? {{(METRIC_W-1){1'b0}}, w_match}
                                         : r_acc + {{(METRIC_W-1){1'b0}}, w_match};

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_acc <= '0;
                end else begin
                    r_acc <= o_metric[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/qpsk_demod.sv
// Non-coherent hard-decision QPSK demodulator: 8-sample windows correlated
// against four templates, argmax decision, 2-bit serialiser and error counter.
module qpsk_demod
    import qpsk_pkg::*;
#(
    parameter int ALIGN  = 1,
    parameter int THRESH = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output sym_t       sym,
    output logic       sym_valid,
    output logic       sym_err,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [7:0] err_cnt
);

    localparam logic [2:0]          ALIGN_3  = 3'(ALIGN);
    localparam logic [METRIC_W-1:0] THRESH_M = METRIC_W'(THRESH);

    logic [2:0] r_sc;
    logic       r_primed;
    sym_t       r_sym;
    logic       r_sym_valid;
    logic       r_sym_err;
    logic       r_bit_out;
    logic       r_bit_valid;
    logic       r_pend;
    logic       r_pend_bit;
    logic [7:0] r_err_cnt;

    logic [2:0]                             w_k;
    logic                                   w_load;
    logic                                   w_decide;
    logic [CHIPS_PER_SYM-1:0][METRIC_W-1:0] w_metric;
    logic [METRIC_W-1:0]                    w_best;
    sym_t                                   w_best_sym;
    logic                                   w_err;

    assign w_k      = r_sc - ALIGN_3;
    assign w_load   = (w_k == 3'd0);
    // r_primed keeps a window cut short by reset from producing a decision
    assign w_decide = (w_k == 3'd7) && r_primed;

    qpsk_corr u_corr (
        .clk      (clk),
        .reset    (reset),
        .i_sample (rx),
        .i_chip   (w_k[2:1]),
        .i_load   (w_load),
        .o_metric (w_metric)
    );

    // Strict '>' keeps the lowest code on ties
    always_comb begin
        w_best     = w_metric[0];
        w_best_sym = 2'b00;
        for (int i = 1; i < CHIPS_PER_SYM; i++) begin
            if (w_metric[i] > w_best) begin
                w_best     = w_metric[i];
                w_best_sym = sym_t'(i);
            end
        end
    end

    assign w_err = (w_best < THRESH_M);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sc        <= '0;
            r_primed    <= 1'b0;
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_sym_err   <= 1'b0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_bit  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_sc        <= r_sc + 3'd1;
            r_sym_valid <= 1'b0;
            r_bit_valid <= 1'b0;
            if (w_load) begin
                r_primed <= 1'b1;
            end
            if (w_decide) begin
                r_sym       <= w_best_sym;
                r_sym_err   <= w_err;
                r_sym_valid <= 1'b1;
                r_bit_out   <= w_best_sym[1];
                r_bit_valid <= 1'b1;
                r_pend      <= 1'b1;
                r_pend_bit  <= w_best_sym[0];
                if (w_err && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (r_pend && (w_k == 3'd3)) begin
                // k=3 of the next window is exactly 4 edges after the decision
                r_bit_out   <= r_pend_bit;
                r_bit_valid <= 1'b1;
                r_pend      <= 1'b0;
            end
        end
    end

    assign sym       = r_sym;
    assign sym_valid = r_sym_valid;
    assign sym_err   = r_sym_err;
    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_qpsk_demod.sv
// Directed bench for qpsk_demod: clean/flipped/tied windows, a modulator-style
// symbol stream, mid-window reset and error counter saturation.
module tb_qpsk_demod;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [1:0] sym;
    logic       sym_valid;
    logic       sym_err;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] err_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    int         exp_cnt = 0;
    logic       pend = 1'b0;
    logic       pend_bit = 1'b0;
    logic [1:0] last_sym = 2'b00;

    qpsk_demod #(.ALIGN(1), .THRESH(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .sym       (sym),
        .sym_valid (sym_valid),
        .sym_err   (sym_err),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one sample, let it be captured, then look just after the edge
    task automatic step(input logic b);
        rx = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sym"},       8'(sym),       8'h00);
        chk({tag, "_sym_valid"}, 8'(sym_valid), 8'h00);
        chk({tag, "_sym_err"},   8'(sym_err),   8'h00);
        chk({tag, "_bit_out"},   8'(bit_out),   8'h00);
        chk({tag, "_bit_valid"}, 8'(bit_valid), 8'h00);
        chk({tag, "_err_cnt"},   err_cnt,       8'h00);
    endtask

    // s[0] is sample k=0; checks strobes/holds during the window and the decision
    task automatic window(input logic [0:7] s, input logic [1:0] esym, input logic eerr,
                          input string tag);
        for (int k = 0; k < 8; k++) begin
            step(s[k]);
            if (k < 7) begin
                chk({tag, "_no_sym_valid"}, 8'(sym_valid), 8'h00);
                chk({tag, "_sym_hold"},     8'(sym),       8'(last_sym));
                if (k == 3 && pend) begin
                    chk({tag, "_bit1_valid"}, 8'(bit_valid), 8'h01);
                    chk({tag, "_bit1"},       8'(bit_out),   8'(pend_bit));
                    pend = 1'b0;
                end else begin
                    chk({tag, "_no_bit_valid"}, 8'(bit_valid), 8'h00);
                end
            end
        end
        if (eerr && exp_cnt < 255) exp_cnt++;
        chk({tag, "_sym_valid"}, 8'(sym_valid), 8'h01);
        chk({tag, "_sym"},       8'(sym),       8'(esym));
        chk({tag, "_sym_err"},   8'(sym_err),   8'(eerr));
        chk({tag, "_bit0_valid"},8'(bit_valid), 8'h01);
        chk({tag, "_bit0"},      8'(bit_out),   8'(esym[1]));
        chk({tag, "_err_cnt"},   err_cnt,       8'(exp_cnt));
        pend     = 1'b1;
        pend_bit = esym[0];
        last_sym = esym;
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset = 1'b1;
        step(1'b0);                       // sc=0 edge, not part of a window
        chk("pre_window_valid", 8'(sym_valid), 8'h00);

        window(8'b11000011, 2'b01, 1'b0, "clean01");
        window(8'b01110000, 2'b00, 1'b0, "flip00");
        window(8'b11000111, 2'b01, 1'b0, "flip01");
        window(8'b00101111, 2'b10, 1'b0, "flip10");
        window(8'b00111101, 2'b11, 1'b0, "flip11");
        window(8'b10001101, 2'b10, 1'b1, "two_flip10");
        window(8'b11111111, 2'b00, 1'b1, "tie");

        // Modulator stream 1,0,1,1,0,0,0,1 preceded by the idle symbol
        window(8'b11110000, 2'b00, 1'b0, "e2e_idle");
        window(8'b00001111, 2'b10, 1'b0, "e2e_10");
        window(8'b00111100, 2'b11, 1'b0, "e2e_11");
        window(8'b11110000, 2'b00, 1'b0, "e2e_00");
        window(8'b11000011, 2'b01, 1'b0, "e2e_01");

        // Reset at k=2 while the second serial bit is still pending
        step(1'b1);
        step(1'b1);
        reset = 1'b0;
        step(1'b1);
        chk_reset_state("mid_reset");
        reset    = 1'b1;
        pend     = 1'b0;
        exp_cnt  = 0;
        last_sym = 2'b00;
        step(1'b0);
        chk("post_reset_sym_valid", 8'(sym_valid), 8'h00);
        chk("post_reset_bit_valid", 8'(bit_valid), 8'h00);
        window(8'b00001111, 2'b10, 1'b0, "post_reset");

        for (int w = 0; w < 300; w++) begin
            window(8'b11111111, 2'b00, 1'b1, "sat");
        end
        chk("sat_final", err_cnt, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
